sdram_aref: RTL and testbench
=============================

# sdram_aref

Auto-refresh engine for the SDRAM controller: a sibling stage of the write and read engines, sitting directly upstream of the command arbiter inside `sdram_top`. After `sdram_init` finishes, it times the refresh interval and raises a request to the arbiter. Once granted, it issues PRECHARGE-ALL followed by a burst of AUTO REFRESH commands with tRP/tRC spacing, then signals completion so the arbiter can return the bus to read/write traffic.

## Interface
- `REF_PERIOD`, 750: refresh interval in `sclk` cycles (15 µs at 50 MHz; 4096 rows / 64 ms).
- `TRP_CYC`, 2: NOP cycles after PRECHARGE.
- `TRC_CYC`, 4: NOP cycles after each AUTO REFRESH.
- `AREF_NUM`, 2: AUTO REFRESH commands per grant (1..15).

Ports:
- `sclk` in 1: system clock; all logic is rising-edge.
- `s_rst_n` in 1: asynchronous, active-low reset.
- `init_end` in 1: level, high once SDRAM power-up init is complete.
- `aref_en` in 1: grant from the arbiter, held high until `aref_end`.
- `aref_req` out 1: refresh request to the arbiter.
- `aref_end` out 1: one-cycle pulse when the sequence is complete.
- `aref_cmd` out 4: {cs_n, ras_n, cas_n, we_n}. NOP = 4'b0111, PRECHARGE = 4'b0010, AREF = 4'b0001.
- `aref_addr` out 12: SDRAM address. 12'h400 (A10 = 1, all banks) during PRECHARGE, 12'h000 otherwise.

## Operation
**Reset.** Reset is asynchronous and active-low. On reset:
- `aref_req` = 0, `aref_end` = 0, `aref_cmd` = NOP, `aref_addr` = 0.
- FSM goes to IDLE; all counters clear.
- A reset mid-sequence aborts immediately. No `aref_end` is generated.

**Interval timer (`ref_cnt`, 10 bits).**
- Held at 0, and `aref_req` held at 0, while `init_end` = 0.
- Otherwise counts 0..REF_PERIOD-1 and wraps. The interval is measured start-to-start, so the timer free-runs during a refresh sequence.
- On the wrap cycle (`ref_cnt` == REF_PERIOD-1), `aref_req` is set.
- `aref_req` clears on the edge that samples `aref_en` && `aref_req` in IDLE.
- Overrun: if the timer wraps while `aref_req` is still high, `aref_req` stays high. No second request is queued or counted.
- `init_end` falling mid-sequence clears the timer and `aref_req`, but the sequence in progress completes normally.

**FSM states.** IDLE, PRE, TRP, AREF, TRC, DONE.
- IDLE: when `aref_en` && `aref_req` → PRE. `aref_en` without a pending `aref_req` is ignored.
- PRE (1 cycle): `aref_cmd` = PRECHARGE, `aref_addr` = 12'h400 → TRP.
- TRP (TRP_CYC cycles): NOP → AREF.
- AREF (1 cycle): `aref_cmd` = AREF; the 4-bit `aref_num` counter increments → TRC.
- TRC (TRC_CYC cycles): NOP. Then → AREF if `aref_num` < AREF_NUM, else → DONE.
- DONE (1 cycle): `aref_end` = 1, `aref_cmd` = NOP; `aref_num` clears → IDLE.
- `aref_en` is not examined outside IDLE. The arbiter dropping the grant early does not abort the sequence.

**Registers.** All outputs are registered; there is no combinational path from inputs to outputs. A single wait counter (3 bits minimum, sized for max(TRP_CYC, TRC_CYC)) is shared by TRP and TRC and reloads on each state entry.

## Timing
- Cycle numbering: cycle 0 is the edge that samples `aref_en` = 1 in IDLE.
- Cycle 1: `aref_cmd` = PRECHARGE and `aref_req` = 0.
- Cycles 2..1+TRP_CYC: NOP.
- AUTO REFRESH k (k = 1..AREF_NUM) is issued at cycle 2 + TRP_CYC + (k-1)·(1+TRC_CYC).
- `aref_end` is high at cycle 2 + TRP_CYC + AREF_NUM·(1+TRC_CYC), i.e. cycle 14 with defaults.
- The FSM is back in IDLE at cycle 15 with defaults; a new grant can be accepted from then on.
- First `aref_req` rises REF_PERIOD cycles after the first cycle with `init_end` = 1 (cycle 750 with defaults). Subsequent requests follow every REF_PERIOD cycles.
- Request latency to the arbiter is 1 registered cycle after the timer wrap.

## Test plan
- **Reset and init.** Hold `init_end` = 0 for 2000 cycles → `aref_req` = 0, `aref_cmd` = 4'b0111, `aref_addr` = 0 throughout.
- **Periodic request.** Raise `init_end` and never grant → `aref_req` rises at cycle 750 and stays high. At cycle 1500 there is no extra pulse and no glitch.
- **Full sequence.** Grant one cycle after `aref_req` rises, hold until `aref_end` → PRECHARGE with addr 12'h400 at +1, AREF at +4 and +9, NOP everywhere else, `aref_end` single pulse at +14. The SDRAM model reports no tRP/tRC violation.
- **Back-to-back.** Grant each request immediately for 5 intervals → exactly 5 PRECHARGE and 10 AREF commands, with request rising edges 750 cycles apart.
- **Reset mid-sequence.** Assert `s_rst_n` = 0 at cycle +6 of a sequence → outputs return to reset values asynchronously and `aref_end` never pulses. After release, the next `aref_req` comes 750 cycles after `init_end` is seen high.
- **Spurious and early grant.** `aref_en` pulsed with no pending request → no command issued. `aref_en` dropped at +3 of a valid sequence → the sequence still completes with `aref_end` at +14.

Source files
------------

// File: rtl/sdram_aref.sv
// Auto-refresh engine: times the refresh interval after init, requests the bus,
// then issues PRECHARGE-ALL and a burst of AUTO REFRESH commands with tRP/tRC spacing.
module sdram_aref #(
    parameter int REF_PERIOD = 750,
    parameter int TRP_CYC    = 2,
    parameter int TRC_CYC    = 4,
    parameter int AREF_NUM   = 2
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic        aref_end,
    output logic [3:0]  aref_cmd,
    output logic [11:0] aref_addr
);

    localparam int WAIT_MAX = (TRP_CYC > TRC_CYC) ? TRP_CYC : TRC_CYC;
    localparam int WAIT_W   = ($clog2(WAIT_MAX + 1) > 3) ? $clog2(WAIT_MAX + 1) : 3;

    localparam logic [WAIT_W-1:0] TRP_LOAD   = WAIT_W'(TRP_CYC - 1);
    localparam logic [WAIT_W-1:0] TRC_LOAD   = WAIT_W'(TRC_CYC - 1);
    localparam logic [9:0]        REF_LAST   = 10'(REF_PERIOD - 1);
    localparam logic [3:0]        AREF_TOTAL = 4'(AREF_NUM);

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_PRE  = 4'b0010;
    localparam logic [3:0]  CMD_AREF = 4'b0001;
    localparam logic [11:0] ADDR_ALL = 12'h400;
    localparam logic [11:0] ADDR_0   = 12'h000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_TRP  = 3'd2,
        ST_AREF = 3'd3,
        ST_TRC  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t            state_r;
    logic [9:0]        ref_cnt_r;
    logic              aref_req_r;
    logic [WAIT_W-1:0] wait_r;
    logic [3:0]        aref_num_r;
    logic              aref_end_r;
    logic [3:0]        aref_cmd_r;
    logic [11:0]       aref_addr_r;

    logic              wrap_s;
    logic              accept_s;

    assign wrap_s   = (ref_cnt_r == REF_LAST);
    assign accept_s = (state_r == ST_IDLE) && aref_en && aref_req_r;

    assign aref_req  = aref_req_r;
    assign aref_end  = aref_end_r;
    assign aref_cmd  = aref_cmd_r;
    assign aref_addr = aref_addr_r;

    // Free-running interval timer and sticky request; a wrap wins over a same-cycle accept
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            ref_cnt_r  <= 10'd0;
            aref_req_r <= 1'b0;
        end else if (!init_end) begin
            ref_cnt_r  <= 10'd0;
            aref_req_r <= 1'b0;
        end else begin
            if (wrap_s) begin
                ref_cnt_r <= 10'd0;
            end else begin
                ref_cnt_r <= ref_cnt_r + 10'd1;
            end
            if (wrap_s) begin
                aref_req_r <= 1'b1;
            end else if (accept_s) begin
                aref_req_r <= 1'b0;
            end else begin
                aref_req_r <= aref_req_r;
            end
        end
    end

    // Refresh sequencer; outputs are loaded together with the state they belong to
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_r     <= ST_IDLE;
            wait_r      <= '0;
            aref_num_r  <= 4'd0;
            aref_end_r  <= 1'b0;
            aref_cmd_r  <= CMD_NOP;
            aref_addr_r <= ADDR_0;
        end else begin
            aref_end_r  <= 1'b0;
            aref_cmd_r  <= CMD_NOP;
            aref_addr_r <= ADDR_0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r     <= ST_PRE;
                        aref_cmd_r  <= CMD_PRE;
                        aref_addr_r <= ADDR_ALL;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PRE: begin
                    state_r <= ST_TRP;
                    wait_r  <= TRP_LOAD;
                end
                ST_TRP: begin
                    if (wait_r == '0) begin
                        state_r    <= ST_AREF;
                        aref_cmd_r <= CMD_AREF;
                        aref_num_r <= aref_num_r + 4'd1;
                    end else begin
                        wait_r <= wait_r - 1'b1;
                    end
                end
                ST_AREF: begin
                    state_r <= ST_TRC;
                    wait_r  <= TRC_LOAD;
                end
                ST_TRC: begin
                    if (wait_r != '0) begin
                        wait_r <= wait_r - 1'b1;
                    end else if (aref_num_r < AREF_TOTAL) begin
                        state_r    <= ST_AREF;
                        aref_cmd_r <= CMD_AREF;
                        aref_num_r <= aref_num_r + 4'd1;
                    end else begin
                        state_r    <= ST_DONE;
                        aref_end_r <= 1'b1;
                        aref_num_r <= 4'd0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    wait_r     <= '0;
                    aref_num_r <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_aref.sv
// Directed bench for sdram_aref: init hold-off, periodic request, refresh
// sequence timing, back-to-back grants, mid-sequence reset and spurious/early grants.
module tb_sdram_aref;

    logic        sclk;
    logic        s_rst_n;
    logic        init_end;
    logic        aref_en;
    logic        aref_req;
    logic        aref_end;
    logic [3:0]  aref_cmd;
    logic [11:0] aref_addr;

    int vec_cnt;
    int err_cnt;
    int cyc;
    int pre_cnt;
    int aref_cnt;
    int end_cnt;

    sdram_aref dut (
        .sclk      (sclk),
        .s_rst_n   (s_rst_n),
        .init_end  (init_end),
        .aref_en   (aref_en),
        .aref_req  (aref_req),
        .aref_end  (aref_end),
        .aref_cmd  (aref_cmd),
        .aref_addr (aref_addr)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Command/pulse tallies sampled mid-cycle, away from the active edge
    initial begin
        pre_cnt  = 0;
        aref_cnt = 0;
        end_cnt  = 0;
    end
    always @(negedge sclk) begin
        if (aref_cmd == 4'b0010) pre_cnt++;
        if (aref_cmd == 4'b0001) aref_cnt++;
        if (aref_end === 1'b1) end_cnt++;
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
        cyc++;
    endtask

    task automatic wait_req(output int at);
        int n;
        n = 0;
        while (aref_req !== 1'b1 && n < 800) begin
            tick();
            n++;
        end
        check_vec("req_arrival", 32'(aref_req === 1'b1), 32'd1);
        at = cyc;
    endtask

    // Grant now and check cycles +1..+16 of the sequence; the grant is dropped after cycle drop_at
    task automatic run_seq(input string name, input int drop_at);
        logic [3:0]  exp_cmd;
        logic [11:0] exp_addr;
        logic        exp_end;
        aref_en = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            tick();
            exp_cmd  = 4'b0111;
            exp_addr = 12'h000;
            exp_end  = 1'b0;
            if (j == 1) begin
                exp_cmd  = 4'b0010;
                exp_addr = 12'h400;
            end
            if (j == 4 || j == 9) exp_cmd = 4'b0001;
            if (j == 14) exp_end = 1'b1;
            check_vec($sformatf("%s_cmd_c%0d", name, j), 32'(aref_cmd), 32'(exp_cmd));
            check_vec($sformatf("%s_addr_c%0d", name, j), 32'(aref_addr), 32'(exp_addr));
            check_vec($sformatf("%s_end_c%0d", name, j), 32'(aref_end), 32'(exp_end));
            if (j == 1) check_vec($sformatf("%s_req_c1", name), 32'(aref_req), 32'd0);
            if (j == drop_at) aref_en = 1'b0;
        end
        aref_en = 1'b0;
    endtask

    initial begin
        int bad;
        int t[5];
        int tmp;
        int pre0;
        int aref0;
        int end0;
        vec_cnt  = 0;
        err_cnt  = 0;
        cyc      = 0;
        s_rst_n  = 1'b1;
        init_end = 1'b0;
        aref_en  = 1'b0;

        // Reset values
        #2 s_rst_n = 1'b0;
        #1;
        check_vec("rst_req", 32'(aref_req), 32'd0);
        check_vec("rst_end", 32'(aref_end), 32'd0);
        check_vec("rst_cmd", 32'(aref_cmd), 32'h7);
        check_vec("rst_addr", 32'(aref_addr), 32'h0);
        tick();
        tick();
        s_rst_n = 1'b1;

        // init_end low: nothing happens for 2000 cycles
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (aref_req !== 1'b0 || aref_cmd !== 4'b0111 || aref_addr !== 12'h000) bad++;
        end
        check_vec("init_hold_bad", 32'(bad), 32'd0);

        // Periodic request, never granted: rises after 750 cycles and stays high
        init_end = 1'b1;
        bad = 0;
        for (int i = 1; i <= 1600; i++) begin
            tick();
            if (i == 749) check_vec("first_req_749", 32'(aref_req), 32'd0);
            if (i == 750) check_vec("first_req_750", 32'(aref_req), 32'd1);
            if (i > 750 && (aref_req !== 1'b1 || aref_cmd !== 4'b0111)) bad++;
        end
        check_vec("overrun_bad", 32'(bad), 32'd0);

        // Full sequence on the pending request
        run_seq("full", 14);

        // Back-to-back: five intervals, each granted immediately
        pre0  = pre_cnt;
        aref0 = aref_cnt;
        end0  = end_cnt;
        for (int k = 0; k < 5; k++) begin
            wait_req(t[k]);
            run_seq($sformatf("b2b%0d", k), 14);
        end
        for (int k = 1; k < 5; k++) begin
            check_vec($sformatf("b2b_space%0d", k), 32'(t[k] - t[k-1]), 32'd750);
        end
        check_vec("b2b_pre_count", 32'(pre_cnt - pre0), 32'd5);
        check_vec("b2b_aref_count", 32'(aref_cnt - aref0), 32'd10);
        check_vec("b2b_end_count", 32'(end_cnt - end0), 32'd5);

        // Reset at +6 of a sequence
        wait_req(tmp);
        aref_en = 1'b1;
        repeat (6) tick();
        end0 = end_cnt;
        pre0 = pre_cnt;
        s_rst_n = 1'b0;
        aref_en = 1'b0;
        #1;
        check_vec("midrst_req", 32'(aref_req), 32'd0);
        check_vec("midrst_end", 32'(aref_end), 32'd0);
        check_vec("midrst_cmd", 32'(aref_cmd), 32'h7);
        check_vec("midrst_addr", 32'(aref_addr), 32'h0);
        repeat (3) tick();
        s_rst_n = 1'b1;
        for (int i = 1; i <= 750; i++) begin
            tick();
            if (i == 749) check_vec("rst_req_749", 32'(aref_req), 32'd0);
            if (i == 750) check_vec("rst_req_750", 32'(aref_req), 32'd1);
        end
        check_vec("midrst_no_end", 32'(end_cnt - end0), 32'd0);
        check_vec("midrst_no_pre", 32'(pre_cnt - pre0), 32'd0);

        // Serve the pending request, then a spurious grant with none pending
        run_seq("serve", 14);
        pre0  = pre_cnt;
        aref0 = aref_cnt;
        aref_en = 1'b1;
        repeat (3) tick();
        aref_en = 1'b0;
        repeat (10) tick();
        check_vec("spur_no_pre", 32'(pre_cnt - pre0), 32'd0);
        check_vec("spur_no_aref", 32'(aref_cnt - aref0), 32'd0);

        // Early grant drop at +3 still completes the sequence
        wait_req(tmp);
        run_seq("early", 3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
